// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   Bundles the I-cache, D-cache and main-memory signals of the cache/memory
//   arbiter.
//   Modports:
//     master - arbiter side: samples cache requests and memory responses,
//              drives cache responses, memory beat requests, Owner and CacheStall.
//     slave  - environment side (caches + memory + hazard unit).
//   Signal groups:
//     I-cache : IReq, IAddr -> IRData, IRValid, IDone
//     D-cache : DReq, DWrite, DAddr, DWData -> DWReady, DRData, DRValid, DDone
//     Memory  : MemReq, MemWrite, MemAddr, MemWData -> MemRData, MemAck
//     Status  : Owner, CacheStall
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRData;
  logic              IRValid;
  logic              IDone;

  logic              DReq;
  logic              DWrite;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DWReady;
  logic [DATA_W-1:0] DRData;
  logic              DRValid;
  logic              DDone;

  logic              MemReq;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;

  logic              Owner;
  logic              CacheStall;

  modport master (
    input  IReq, IAddr, DReq, DWrite, DAddr, DWData, MemRData, MemAck,
    output IRData, IRValid, IDone, DWReady, DRData, DRValid, DDone,
           MemReq, MemWrite, MemAddr, MemWData, Owner, CacheStall
  );

  modport slave (
    output IReq, IAddr, DReq, DWrite, DAddr, DWData, MemRData, MemAck,
    input  IRData, IRValid, IDone, DWReady, DRData, DRValid, DDone,
           MemReq, MemWrite, MemAddr, MemWData, Owner, CacheStall
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Arbitrates I-cache refills and D-cache refills/write-backs onto one
//   main-memory port. Runs a BEATS-word burst for the granted cache, routes
//   read data back to it, and drives CacheStall to the hazard unit.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - cache_mem_arbiter_if.master (cache, memory and status signals)
//   Build option:
//     ARB_ROUND_ROBIN_EN - when defined, a last-served bit alternates priority
//                          between I and D on simultaneous requests; otherwise
//                          D always wins over I.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no burst; arbitrate and capture base/write flag/owner
//   XFER  | MemReq high; one beat retired per MemAck
//   DONE  | one-cycle Done pulse to the owner; requests ignored
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_mem_arbiter_if.master bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int LOG_B  = $clog2(BYTES);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = BEAT_W + LOG_B;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_base;
  logic              r_write;
  logic              r_owner;
  logic [DATA_W-1:0] r_irdata;
  logic [DATA_W-1:0] r_drdata;
  logic              r_irvalid;
  logic              r_drvalid;

  logic              w_any_req;
  logic              w_grant_d;
  logic              w_grant;
  logic              w_beat_ack;
  logic              w_last_ack;
  logic              w_rd_beat_i;
  logic              w_rd_beat_d;
  logic [ADDR_W-1:0] w_req_addr;

  assign w_any_req   = bus.IReq | bus.DReq;
  assign w_grant     = (r_state == IDLE) & w_any_req;
  assign w_beat_ack  = (r_state == XFER) & bus.MemAck;
  assign w_last_ack  = w_beat_ack & (r_beat == LAST_BEAT);
  assign w_rd_beat_i = w_beat_ack & ~r_write & ~r_owner;
  assign w_rd_beat_d = w_beat_ack & ~r_write & r_owner;
  assign w_req_addr  = w_grant_d ? bus.DAddr : bus.IAddr;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D was granted last; on a tie the other requester wins.
  logic r_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last_d <= 1'b0;
    else if (w_grant) r_last_d <= w_grant_d;
  end

  assign w_grant_d = bus.DReq & (~bus.IReq | ~r_last_d);
`else
  assign w_grant_d = bus.DReq;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req)  w_next_state = XFER;
      XFER:    if (w_last_ack) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Burst context and registered read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_base    <= '0;
      r_write   <= 1'b0;
      r_owner   <= 1'b0;
      r_irdata  <= '0;
      r_drdata  <= '0;
      r_irvalid <= 1'b0;
      r_drvalid <= 1'b0;
    end else begin
      // RData is zero outside its valid pulse so the non-owner stays quiet.
      r_irvalid <= w_rd_beat_i;
      r_drvalid <= w_rd_beat_d;
      r_irdata  <= w_rd_beat_i ? bus.MemRData : '0;
      r_drdata  <= w_rd_beat_d ? bus.MemRData : '0;
      if (w_grant) begin
        r_owner <= w_grant_d;
        r_write <= w_grant_d & bus.DWrite;
        r_base  <= w_req_addr & ~OFF_MASK;
        r_beat  <= '0;
      end else if (w_beat_ack) begin
        r_beat  <= r_beat + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.MemReq   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemAddr  = '0;
    bus.MemWData = '0;
    bus.DWReady  = 1'b0;
    bus.IDone    = 1'b0;
    bus.DDone    = 1'b0;
    case (r_state)
      XFER: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = r_write;
        bus.MemAddr  = r_base + (ADDR_W'(r_beat) << LOG_B);
        bus.MemWData = r_write ? bus.DWData : '0;
        // r_write is only ever set for a D-cache owner.
        bus.DWReady  = r_write & bus.MemAck;
      end
      DONE: begin
        bus.IDone = ~r_owner;
        bus.DDone = r_owner;
      end
      default: ;
    endcase
  end

  assign bus.IRData     = r_irdata;
  assign bus.IRValid    = r_irvalid;
  assign bus.DRData     = r_drdata;
  assign bus.DRValid    = r_drvalid;
  assign bus.Owner      = r_owner;
  assign bus.CacheStall = (r_state != IDLE) | bus.IReq | bus.DReq;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int BYTES  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BEATS * BYTES - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 1 = D was served last (round-robin build only).
  bit m_last_d = 1'b0;

  // Observations of the most recent burst, filled by run_burst.
  int ob_cycles, ob_beats, ob_irv, ob_drv, ob_idone, ob_ddone;
  int ob_wready, ob_wready_noack, ob_writes, ob_stray, ob_nostall;
  bit ob_timeout, ob_owner, ob_done_rv, ob_first_busy;
  logic [ADDR_W-1:0] ob_addr [BEATS];
  logic [DATA_W-1:0] ob_wdata[BEATS];
  logic [DATA_W-1:0] ob_rdata[BEATS];
  logic [DATA_W-1:0] sent_rdata[BEATS];
  logic [DATA_W-1:0] line_wdata[BEATS];

  function automatic bit exp_grant_d(bit i, bit d);
`ifdef ARB_ROUND_ROBIN_EN
    if (i && d) return !m_last_d;
`endif
    return d;
  endfunction

  // Acts as memory and cache requester for one burst; records what it sees.
  // ack_mode: 0 = always, 1 = every other cycle, 2 = random.
  task automatic run_burst(input int ack_mode, input int drop_beat,
                           input bit keep_req, input bit scramble);
    int  wbeat;
    bit  tog;
    bit  done;
    ob_cycles = 0; ob_beats = 0; ob_irv = 0; ob_drv = 0; ob_idone = 0; ob_ddone = 0;
    ob_wready = 0; ob_wready_noack = 0; ob_writes = 0; ob_stray = 0; ob_nostall = 0;
    ob_timeout = 0; ob_owner = 0; ob_done_rv = 0; ob_first_busy = 0;
    for (int k = 0; k < BEATS; k++) begin
      line_wdata[k] = $urandom;
      ob_addr[k] = '0; ob_wdata[k] = '0; ob_rdata[k] = '0; sent_rdata[k] = '0;
    end
    wbeat = 0; tog = 0; done = 0;
    while (!done && ob_cycles < 300) begin
      if (ob_cycles > 0) @(negedge clk);
      ob_cycles++;
      case (ack_mode)
        0:       bus.MemAck = 1'b1;
        1:       begin bus.MemAck = tog; tog = ~tog; end
        default: bus.MemAck = 1'($urandom_range(0, 1));
      endcase
      bus.MemRData = $urandom;
      bus.DWData   = line_wdata[wbeat];
      #1;
      if (ob_cycles == 1) ob_first_busy = bus.MemReq | bus.IDone | bus.DDone;
      if (!bus.CacheStall) ob_nostall++;
      if (bus.IRValid) begin
        if (ob_irv + ob_drv < BEATS) ob_rdata[ob_irv + ob_drv] = bus.IRData;
        ob_irv++;
      end else if (bus.IRData !== '0) ob_stray++;
      if (bus.DRValid) begin
        if (ob_irv + ob_drv < BEATS) ob_rdata[ob_irv + ob_drv] = bus.DRData;
        ob_drv++;
      end else if (bus.DRData !== '0) ob_stray++;
      if (bus.DWReady) begin
        ob_wready++;
        if (!(bus.MemReq && bus.MemAck)) ob_wready_noack++;
      end
      if (bus.MemReq && bus.MemAck) begin
        if (ob_beats == 0) ob_owner = bus.Owner;
        if (ob_beats < BEATS) begin
          ob_addr[ob_beats]    = bus.MemAddr;
          ob_wdata[ob_beats]   = bus.MemWData;
          sent_rdata[ob_beats] = bus.MemRData;
        end
        if (bus.MemWrite) ob_writes++;
        ob_beats++;
        if (ob_beats == drop_beat) begin bus.IReq = 0; bus.DReq = 0; end
      end
      if (bus.IDone || bus.DDone) begin
        ob_idone += int'(bus.IDone);
        ob_ddone += int'(bus.DDone);
        ob_done_rv = bus.IRValid | bus.DRValid;
        done = 1;
        if (!keep_req) begin
          if (bus.IDone) bus.IReq = 0;
          if (bus.DDone) bus.DReq = 0;
        end
      end
      if (bus.DWReady && wbeat < BEATS - 1) wbeat++;
      if (scramble && ob_beats > 0) begin
        bus.IAddr = $urandom; bus.DAddr = $urandom; bus.DWrite = 1'($urandom_range(0, 1));
      end
    end
    bus.MemAck = 0;
    if (!done) ob_timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.IReq = 1; bus.DReq = 1; bus.DWrite = 0;
    bus.IAddr = 32'h0000_4008; bus.DAddr = 32'h0000_3004;
    bus.MemAck = 1; bus.MemRData = $urandom; bus.DWData = $urandom;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.MemReq, bus.MemWrite, bus.IRValid, bus.DRValid, bus.IDone, bus.DDone,
         bus.DWReady, bus.Owner} !== 8'h00 || bus.MemAddr !== '0 || bus.MemWData !== '0 ||
        bus.IRData !== '0 || bus.DRData !== '0) begin
      failures++; $display("FAIL reset_outputs got req=%0b addr=%0h owner=%0b exp all zero",
                           bus.MemReq, bus.MemAddr, bus.Owner);
    end
    checks++;
    if (bus.CacheStall !== 1'b1) begin
      failures++; $display("FAIL reset_stall got=%0b exp=1", bus.CacheStall);
    end
    @(negedge clk);
    bus.MemAck = 0;
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.Owner !== exp_grant_d(1, 1) || bus.MemReq !== 1'b1) begin
      failures++; $display("FAIL reset_first_grant got owner=%0b req=%0b exp owner=%0b req=1",
                           bus.Owner, bus.MemReq, exp_grant_d(1, 1));
    end
    checks++;
    if (bus.MemAddr !== 32'h0000_3000) begin
      failures++; $display("FAIL reset_first_addr got=%0h exp=3000", bus.MemAddr);
    end
    rst_n = 0; bus.IReq = 0; bus.DReq = 0;
    @(negedge clk);
    rst_n = 1;
    m_last_d = 0;
  endtask

  task automatic test_i_refill();
    logic [ADDR_W-1:0] base;
    @(negedge clk);
    bus.IAddr = 32'h0000_1004; bus.IReq = 1; bus.DReq = 0; bus.DWrite = 0;
    base = 32'h0000_1000;
    run_burst(0, -1, 0, 1);
    checks++;
    if (ob_timeout || ob_cycles != BEATS + 2) begin
      failures++; $display("FAIL i_latency got=%0d timeout=%0b exp=%0d", ob_cycles, ob_timeout, BEATS + 2);
    end
    checks++;
    if (ob_owner !== 1'b0 || ob_beats != BEATS || ob_writes != 0) begin
      failures++; $display("FAIL i_burst got owner=%0b beats=%0d writes=%0d exp 0/%0d/0",
                           ob_owner, ob_beats, ob_writes, BEATS);
    end
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if (ob_addr[k] !== base + ADDR_W'(k * BYTES) || ob_rdata[k] !== sent_rdata[k]) begin
        failures++; $display("FAIL i_beat%0d got addr=%0h data=%0h exp addr=%0h data=%0h",
                             k, ob_addr[k], ob_rdata[k], base + ADDR_W'(k * BYTES), sent_rdata[k]);
      end
    end
    checks++;
    if (ob_irv != BEATS || ob_drv != 0 || ob_idone != 1 || ob_ddone != 0 || !ob_done_rv) begin
      failures++; $display("FAIL i_pulses got irv=%0d drv=%0d idone=%0d ddone=%0d done_rv=%0b exp %0d/0/1/0/1",
                           ob_irv, ob_drv, ob_idone, ob_ddone, ob_done_rv, BEATS);
    end
    checks++;
    if (ob_wready != 0 || ob_stray != 0 || ob_nostall != 0 || ob_first_busy) begin
      failures++; $display("FAIL i_quiet got wready=%0d stray=%0d nostall=%0d busy=%0b exp 0/0/0/0",
                           ob_wready, ob_stray, ob_nostall, ob_first_busy);
    end
    m_last_d = 0;
  endtask

  task automatic test_d_writeback();
    logic [ADDR_W-1:0] base;
    @(negedge clk);
    bus.DAddr = 32'h0000_2010; bus.DWrite = 1; bus.DReq = 1; bus.IReq = 0;
    base = 32'h0000_2010;
    run_burst(1, -1, 0, 1);
    checks++;
    if (ob_timeout || ob_cycles != 2 * BEATS + 1) begin
      failures++; $display("FAIL d_wb_cycles got=%0d timeout=%0b exp=%0d", ob_cycles, ob_timeout, 2 * BEATS + 1);
    end
    checks++;
    if (ob_owner !== 1'b1 || ob_writes != BEATS || ob_wready != BEATS || ob_wready_noack != 0) begin
      failures++; $display("FAIL d_wb_ready got owner=%0b writes=%0d wready=%0d noack=%0d exp 1/%0d/%0d/0",
                           ob_owner, ob_writes, ob_wready, ob_wready_noack, BEATS, BEATS);
    end
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if (ob_addr[k] !== base + ADDR_W'(k * BYTES) || ob_wdata[k] !== line_wdata[k]) begin
        failures++; $display("FAIL d_wb_beat%0d got addr=%0h wdata=%0h exp addr=%0h wdata=%0h",
                             k, ob_addr[k], ob_wdata[k], base + ADDR_W'(k * BYTES), line_wdata[k]);
      end
    end
    checks++;
    if (ob_drv != 0 || ob_irv != 0 || ob_ddone != 1 || ob_idone != 0 || ob_stray != 0) begin
      failures++; $display("FAIL d_wb_pulses got drv=%0d irv=%0d ddone=%0d idone=%0d stray=%0d exp 0/0/1/0/0",
                           ob_drv, ob_irv, ob_ddone, ob_idone, ob_stray);
    end
    m_last_d = 1;
  endtask

  task automatic test_contention();
    bit exp_d;
    logic [ADDR_W-1:0] ia, da;
    ia = $urandom; da = $urandom;
    @(negedge clk);
    bus.IAddr = ia; bus.DAddr = da; bus.DWrite = 0; bus.IReq = 1; bus.DReq = 1;
    for (int j = 0; j < 2; j++) begin
      exp_d = (j == 0) ? exp_grant_d(1, 1) : !exp_d;
      if (j > 0) @(negedge clk);
      run_burst(2, -1, 0, 0);
      checks++;
      if (ob_timeout || ob_owner !== exp_d || ob_beats != BEATS) begin
        failures++; $display("FAIL contention_owner%0d got=%0b beats=%0d exp=%0b beats=%0d",
                             j, ob_owner, ob_beats, exp_d, BEATS);
      end
      checks++;
      if (ob_addr[BEATS-1] !== ((exp_d ? da : ia) & ~LINE_MASK) + ADDR_W'((BEATS - 1) * BYTES)) begin
        failures++; $display("FAIL contention_addr%0d got=%0h exp=%0h", j, ob_addr[BEATS-1],
                             ((exp_d ? da : ia) & ~LINE_MASK) + ADDR_W'((BEATS - 1) * BYTES));
      end
      m_last_d = exp_d;
    end
  endtask

  task automatic test_round_robin();
    bit exp_d;
    @(negedge clk);
    bus.IAddr = $urandom; bus.DAddr = $urandom; bus.DWrite = 0; bus.IReq = 1; bus.DReq = 1;
    for (int j = 0; j < 3; j++) begin
      exp_d = exp_grant_d(1, 1);
      if (j > 0) @(negedge clk);
      run_burst(0, -1, 1, 0);
      checks++;
      if (ob_timeout || ob_owner !== exp_d || ob_cycles != BEATS + 2) begin
        failures++; $display("FAIL rr_grant%0d got owner=%0b cycles=%0d exp owner=%0b cycles=%0d",
                             j, ob_owner, ob_cycles, exp_d, BEATS + 2);
      end
      m_last_d = exp_d;
    end
    bus.IReq = 0; bus.DReq = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.MemReq !== 1'b0 || bus.CacheStall !== 1'b0) begin
      failures++; $display("FAIL rr_idle got req=%0b stall=%0b exp 0/0", bus.MemReq, bus.CacheStall);
    end
  endtask

  task automatic test_mid_drop();
    @(negedge clk);
    bus.DAddr = $urandom; bus.DWrite = 0; bus.DReq = 1; bus.IReq = 0;
    run_burst(2, 1, 0, 0);
    checks++;
    if (ob_timeout || ob_beats != BEATS || ob_drv != BEATS || ob_ddone != 1 || ob_nostall != 0) begin
      failures++; $display("FAIL mid_drop got beats=%0d drv=%0d ddone=%0d nostall=%0d exp %0d/%0d/1/0",
                           ob_beats, ob_drv, ob_ddone, ob_nostall, BEATS, BEATS);
    end
    m_last_d = 1;
  endtask

  task automatic test_reset_mid_burst();
    logic [ADDR_W-1:0] da;
    int busy;
    da = $urandom;
    @(negedge clk);
    bus.DAddr = da; bus.DWrite = 0; bus.DReq = 1; bus.IReq = 0; bus.MemAck = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.MemReq !== 1'b1 || bus.MemAddr !== (da & ~LINE_MASK) + ADDR_W'(2 * BYTES)) begin
      failures++; $display("FAIL abort_pre got req=%0b addr=%0h exp 1/%0h", bus.MemReq, bus.MemAddr,
                           (da & ~LINE_MASK) + ADDR_W'(2 * BYTES));
    end
    rst_n = 0;
    #1;
    checks++;
    if (bus.MemReq !== 1'b0 || bus.DDone !== 1'b0 || bus.DRValid !== 1'b0 || bus.Owner !== 1'b0) begin
      failures++; $display("FAIL abort_reset got req=%0b ddone=%0b drv=%0b owner=%0b exp 0/0/0/0",
                           bus.MemReq, bus.DDone, bus.DRValid, bus.Owner);
    end
    bus.DReq = 0; bus.MemAck = 0;
    @(negedge clk);
    rst_n = 1;
    busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.MemReq || bus.DDone || bus.IDone || bus.DRValid) busy++;
    end
    checks++;
    if (busy != 0) begin
      failures++; $display("FAIL abort_after got busy_cycles=%0d exp=0", busy);
    end
    m_last_d = 0;
  endtask

  task automatic test_random();
    bit ri, rd, dw, exp_d, req_i, req_d;
    logic [ADDR_W-1:0] ia, da, base;
    int nb;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0:       begin ri = 1; rd = 0; end
        1:       begin ri = 0; rd = 1; end
        default: begin ri = 1; rd = 1; end
      endcase
      ia = $urandom; da = $urandom; dw = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.IAddr = ia; bus.DAddr = da; bus.DWrite = dw; bus.IReq = ri; bus.DReq = rd;
      req_i = ri; req_d = rd;
      nb = (ri && rd) ? 2 : 1;
      for (int j = 0; j < nb; j++) begin
        exp_d = exp_grant_d(req_i, req_d);
        base = (exp_d ? da : ia) & ~LINE_MASK;
        if (j > 0) @(negedge clk);
        run_burst(2, -1, 0, 0);
        checks++;
        if (ob_timeout || ob_owner !== exp_d || ob_beats != BEATS ||
            ob_writes != ((exp_d && dw) ? BEATS : 0)) begin
          failures++; $display("FAIL rnd%0d_%0d got owner=%0b beats=%0d writes=%0d exp owner=%0b beats=%0d write=%0b",
                               it, j, ob_owner, ob_beats, ob_writes, exp_d, BEATS, exp_d && dw);
        end
        for (int k = 0; k < BEATS; k++) begin
          checks++;
          if (ob_addr[k] !== base + ADDR_W'(k * BYTES) ||
              (exp_d && dw && ob_wdata[k] !== line_wdata[k]) ||
              (!(exp_d && dw) && ob_rdata[k] !== sent_rdata[k])) begin
            failures++; $display("FAIL rnd%0d_%0d_beat%0d got addr=%0h exp addr=%0h", it, j, k,
                                 ob_addr[k], base + ADDR_W'(k * BYTES));
          end
        end
        checks++;
        if (ob_idone != int'(!exp_d) || ob_ddone != int'(exp_d) ||
            ob_irv != (exp_d ? 0 : BEATS) || ob_drv != ((exp_d && !dw) ? BEATS : 0) ||
            ob_wready != ((exp_d && dw) ? BEATS : 0) || ob_wready_noack != 0 || ob_stray != 0) begin
          failures++; $display("FAIL rnd%0d_%0d_pulses got idone=%0d ddone=%0d irv=%0d drv=%0d wready=%0d stray=%0d",
                               it, j, ob_idone, ob_ddone, ob_irv, ob_drv, ob_wready, ob_stray);
        end
        m_last_d = exp_d;
        if (exp_d) req_d = 0; else req_i = 0;
      end
    end
  endtask

  initial begin
    bus.IReq = 0; bus.IAddr = '0; bus.DReq = 0; bus.DWrite = 0; bus.DAddr = '0;
    bus.DWData = '0; bus.MemRData = '0; bus.MemAck = 0;
    test_reset();
    test_i_refill();
    test_d_writeback();
    test_contention();
    test_round_robin();
    test_mid_drop();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences cache-line transfers between the two L1 caches and the single main-memory port.
- The instruction cache requests line refills; the data cache requests refills or write-backs.
- Picks one owner, runs a BEATS-word burst on the memory port, routes data back to the owner, and drives CacheStall into the pipeline hazard unit.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width; byte stride per beat = DATA_W/8.
- BEATS, 4, words per cache line; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IReq  in  1  I-cache line refill request.
- IAddr  in  ADDR_W  I-cache miss address; line-offset bits are ignored.
- IRData  out  DATA_W  refill word to the I-cache.
- IRValid  out  1  IRData valid, one pulse per beat.
- IDone  out  1  I-cache burst complete, one-cycle pulse.
- DReq  in  1  D-cache transfer request.
- DWrite  in  1  1 = write-back, 0 = refill.
- DAddr  in  ADDR_W  D-cache line address; line-offset bits are ignored.
- DWData  in  DATA_W  current write-back beat data.
- DWReady  out  1  current write beat accepted; D-cache advances to the next word.
- DRData  out  DATA_W  refill word to the D-cache.
- DRValid  out  1  DRData valid, one pulse per beat.
- DDone  out  1  D-cache burst complete, one-cycle pulse.
- MemReq  out  1  memory beat request.
- MemWrite  out  1  memory beat is a write.
- MemAddr  out  ADDR_W  memory beat byte address.
- MemWData  out  DATA_W  memory write data.
- MemRData  in  DATA_W  memory read data.
- MemAck  in  1  beat complete; valid only while MemReq=1.
- Owner  out  1  current grant: 0 = I-cache, 1 = D-cache.
- CacheStall  out  1  freeze signal to the pipeline hazard unit.

Behaviour:
- States: IDLE, XFER, DONE.
- Reset (async, rst_n=0):
  - state=IDLE, beat counter=0, Owner=0.
  - All Valid, Done, Ready and Mem* outputs = 0; IRData/DRData = 0.
  - A burst in flight is abandoned; memory must tolerate an aborted burst.
- IDLE:
  - Arbitration: DReq wins over IReq when both are high (fixed priority).
  - On a grant, capture the line base address (Addr with the low log2(BEATS)+log2(DATA_W/8) bits cleared), the write flag (DWrite for D, 0 for I) and Owner; clear the beat counter; go to XFER next cycle.
  - With no request, stay in IDLE.
- XFER:
  - MemReq=1; MemWrite = captured write flag.
  - MemAddr = base + beat*(DATA_W/8). MemWData = DWData, passed through combinationally.
  - Beat acceptance on a cycle with MemAck=1:
    - beat increments.
    - Write burst: DWReady=1 in the same cycle (combinational from MemAck).
    - Read burst: MemRData is registered into the owner's RData, and the owner's RValid=1 on the following cycle.
  - On MemAck for beat BEATS-1, go to DONE.
  - MemAck=0 holds all outputs (wait states allowed, unbounded).
- DONE:
  - Owner's Done=1 for exactly one cycle; for reads it coincides with the last RValid. MemReq=0.
  - Next state = IDLE; requests are not sampled in DONE.
  - The requester must drop Req on the Done cycle; Req still high in the next IDLE is a new request.
- Req deasserted mid-burst is ignored; the burst always completes.
- Req/Addr changes after the grant are ignored (captured values are used).
- Non-owner outputs stay 0 throughout.
- MemAck while MemReq=0 is ignored.
- CacheStall = (state != IDLE) | IReq | DReq; combinational, so the pipeline freezes in the cycle a miss is raised.
- Latency: zero-wait memory gives BEATS+2 cycles from Req to Done (1 grant, BEATS beats, 1 done).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-served register (reset 0 = I) gives priority to the requester not served last when both request in IDLE; a single requester is always granted.
- Undefined: fixed D-over-I priority; the register is absent. I-cache starvation is acceptable because the pipeline is stalled during D traffic.

Test Plan:
- Reset: hold rst_n=0 with IReq=DReq=1 -> all outputs 0 and CacheStall=1; release -> grant to D next cycle, Owner=1.
- I refill: IAddr=0x1004, MemAck every cycle, MemRData=0xA0..0xA3 -> MemAddr 0x1000/0x1004/0x1008/0x100C; IRValid four pulses carrying 0xA0..0xA3; IDone with the last; total 6 cycles.
- D write-back: DAddr=0x2010, DWrite=1, MemAck high every other cycle -> MemWrite=1; MemAddr 0x2010..0x201C; DWReady pulses exactly on the 4 MemAck cycles; DDone once; DRValid never.
- Contention: IReq and DReq rise together -> D burst first, then I. With ARB_ROUND_ROBIN_EN and both held -> grants alternate D, I, D.
- Mid-burst events: DReq dropped after beat 1 -> burst still completes 4 beats. rst_n pulsed low at beat 2 -> MemReq=0 immediately, state IDLE, no Done.
